// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small circular FIFO; bit timing in CLKS_PER_BIT clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module uart_tx #(
  parameter int CLKS_PER_BIT    = 870,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Tx_DV,
  input  logic [7:0]               i_Tx_Byte,
  output logic                     o_Tx_Ready,
  output logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count,
  output logic                     o_Tx_Active,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Done
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   FCNT_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                     state, state_nx;
  logic [CNT_W-1:0]           clk_cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shift_reg;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push, pop, tick;
  logic                       line_d, active_d, done_d;

  assign o_Tx_Ready   = (count != CNT_FULL);
  assign o_Fifo_Count = count;
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign tick         = (clk_cnt == CNT_LAST);

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge i_Clock)
    if (push) mem[wr_ptr] <= i_Tx_Byte;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state   <= state_nx;
      clk_cnt <= (state == IDLE || tick) ? '0 : clk_cnt + CNT_ONE;
      if (state != DATA) bit_idx <= '0;
      else if (tick)     bit_idx <= bit_idx + 3'd1;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_ONE;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + FCNT_ONE;
        2'b01:   count <= count - FCNT_ONE;
        default: count <= count;
      endcase
      // Line, active and done share one register stage so they stay aligned.
      o_Tx_Serial <= line_d;
      o_Tx_Active <= active_d;
      o_Tx_Done   <= done_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (count != '0) state_nx = START;
      START: if (tick) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && bit_idx == 3'd7) state_nx = PARITY;
      PARITY: if (tick) state_nx = STOP;
`else
      DATA:  if (tick && bit_idx == 3'd7) state_nx = STOP;
`endif
      STOP:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    line_d   = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state)
      START: begin line_d = 1'b0; active_d = 1'b1; end
      DATA:  begin line_d = shift_reg[bit_idx]; active_d = 1'b1; end
`ifdef UART_TX_PARITY_EN
      PARITY: begin line_d = ^shift_reg; active_d = 1'b1; end
`endif
      STOP:  begin active_d = 1'b1; done_d = tick; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back, FIFO full,
// mid-frame reset, wide bit counter (870 clocks/bit) and optional parity.
module tb_uart_tx;
  localparam int C  = 8;
  localparam int C2 = 870;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;
  localparam int RN = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, dv = 1'b0, dv2 = 1'b0;
  logic [7:0] tb_byte = 8'h00, byte2 = 8'h00;
  logic       rdy, act, ser, done, rdy2, act2, ser2, done2;
  logic [2:0] cnt, cnt2;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(2)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(tb_byte),
    .o_Tx_Ready(rdy), .o_Fifo_Count(cnt), .o_Tx_Active(act),
    .o_Tx_Serial(ser), .o_Tx_Done(done));

  uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH_LOG2(2)) u_slow (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(rdy2), .o_Fifo_Count(cnt2), .o_Tx_Active(act2),
    .o_Tx_Serial(ser2), .o_Tx_Done(done2));

  int checks = 0, errors = 0;
  logic       s_ser [RN];
  logic       s_act [RN];
  logic       s_done[RN];
  logic [2:0] s_cnt [RN];

  // Samples outputs at the current falling edge, then advances one cycle.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      s_ser[i] = ser; s_act[i] = act; s_done[i] = done; s_cnt[i] = cnt;
      @(negedge clk);
    end
  endtask

  function automatic int find_fall(input int from, input int n);
    for (int i = from; i < n; i++) if (s_ser[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] dec(input int f);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = s_ser[f + C/2 + (j+1)*C];
    return d;
  endfunction

  function automatic int count_hi(input int from, input int to, input bit use_done);
    int n = 0;
    for (int i = from; i < to; i++)
      if ((use_done ? s_done[i] : s_act[i]) === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_lo_ser(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (s_ser[i] !== 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ser !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", ser); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", act); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy); end
    checks++; if (ser2 !== 1'b1) begin errors++; $display("FAIL reset_serial_slow: got %b expected 1", ser2); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int f;
    logic [10:0] exp_bits;
`ifdef UART_TX_PARITY_EN
    exp_bits = 11'b101_0100_1010;
`else
    exp_bits = 11'b011_0100_1010;
`endif
    dv = 1'b1; tb_byte = 8'hA5;
    @(negedge clk);
    dv = 1'b0;
    record(FL + 40);
    f = find_fall(0, FL + 40);
    checks++; if (f !== 2) begin errors++; $display("FAIL a5_latency: fall at %0d expected 2", f); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (s_ser[f + C/2 + i*C] !== exp_bits[i]) begin
        errors++; $display("FAIL a5_bit%0d: got %b expected %b", i, s_ser[f + C/2 + i*C], exp_bits[i]);
      end
    end
    checks++; if (count_hi(0, FL + 40, 1'b0) !== FL) begin errors++; $display("FAIL a5_active_len: got %0d expected %0d", count_hi(0, FL + 40, 1'b0), FL); end
    checks++; if (count_hi(0, FL + 40, 1'b1) !== 1) begin errors++; $display("FAIL a5_done_count: got %0d expected 1", count_hi(0, FL + 40, 1'b1)); end
    checks++; if (s_done[f + FL - 1] !== 1'b1) begin errors++; $display("FAIL a5_done_pos: got %b expected 1", s_done[f + FL - 1]); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c0, c1;
    logic [7:0] exp_b [3];
    int f;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    dv = 1'b1; tb_byte = 8'h00;
    @(negedge clk); c0 = cnt; tb_byte = 8'hFF;
    @(negedge clk); c1 = cnt; tb_byte = 8'h3C;
    @(negedge clk); dv = 1'b0;
    record(3*FL + 40);
    checks++; if (c0 !== 3'd1) begin errors++; $display("FAIL b2b_count0: got %0d expected 1", c0); end
    checks++; if (c1 !== 3'd1) begin errors++; $display("FAIL b2b_count1: got %0d expected 1", c1); end
    checks++; if (s_cnt[0] !== 3'd2) begin errors++; $display("FAIL b2b_count2: got %0d expected 2", s_cnt[0]); end
    checks++; if (s_cnt[FL-1] !== 3'd2) begin errors++; $display("FAIL b2b_count_pre_pop: got %0d expected 2", s_cnt[FL-1]); end
    checks++; if (s_cnt[FL] !== 3'd1) begin errors++; $display("FAIL b2b_count_pop1: got %0d expected 1", s_cnt[FL]); end
    checks++; if (s_cnt[2*FL+1] !== 3'd0) begin errors++; $display("FAIL b2b_count_pop2: got %0d expected 0", s_cnt[2*FL+1]); end
    for (int k = 0; k < 3; k++) begin
      f = find_fall(k == 0 ? 0 : k*(FL+1) - 1, 3*FL + 40);
      checks++; if (f !== k*(FL+1)) begin errors++; $display("FAIL b2b_fall%0d: at %0d expected %0d", k, f, k*(FL+1)); end
      checks++; if (dec(k*(FL+1)) !== exp_b[k]) begin errors++; $display("FAIL b2b_data%0d: got %02h expected %02h", k, dec(k*(FL+1)), exp_b[k]); end
    end
    checks++; if (count_hi(0, 3*FL + 40, 1'b1) !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", count_hi(0, 3*FL + 40, 1'b1)); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_b [5];
    int f;
    exp_b[0] = 8'h11; exp_b[1] = 8'h21; exp_b[2] = 8'h32; exp_b[3] = 8'h43; exp_b[4] = 8'h54;
    fork
      record(RN);
      begin
        dv = 1'b1; tb_byte = exp_b[0];
        @(negedge clk); dv = 1'b0;
        repeat (5) @(negedge clk);
        dv = 1'b1;
        for (int k = 1; k < 5; k++) begin tb_byte = exp_b[k]; @(negedge clk); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", rdy); end
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", cnt); end
        tb_byte = 8'h65;
        @(negedge clk); dv = 1'b0;
        checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL full_drop_count: got %0d expected 4", cnt); end
      end
    join
    for (int k = 0; k < 5; k++) begin
      f = find_fall(k == 0 ? 0 : 3 + k*(FL+1) - 1, RN);
      checks++; if (f !== 3 + k*(FL+1)) begin errors++; $display("FAIL full_fall%0d: at %0d expected %0d", k, f, 3 + k*(FL+1)); end
      checks++; if (dec(3 + k*(FL+1)) !== exp_b[k]) begin errors++; $display("FAIL full_data%0d: got %02h expected %02h", k, dec(3 + k*(FL+1)), exp_b[k]); end
    end
    checks++; if (find_fall(3 + 5*(FL+1) - 1, RN) !== -1) begin errors++; $display("FAIL full_extra_frame: fall at %0d expected none", find_fall(3 + 5*(FL+1) - 1, RN)); end
    checks++; if (count_hi(0, RN, 1'b1) !== 5) begin errors++; $display("FAIL full_done_count: got %0d expected 5", count_hi(0, RN, 1'b1)); end
  endtask

  task automatic test_reset_mid_frame();
    fork
      record(300);
      begin
        dv = 1'b1; tb_byte = 8'h50;
        @(negedge clk); tb_byte = 8'hC3;
        @(negedge clk); tb_byte = 8'h7E;
        @(negedge clk); dv = 1'b0;
        checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL rst_queued: got %0d expected 2", cnt); end
        repeat (35) @(negedge clk);
        checks++; if (ser !== 1'b0) begin errors++; $display("FAIL rst_bit3_low: got %b expected 0", ser); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (ser !== 1'b1) begin errors++; $display("FAIL rst_line_high: got %b expected 1", ser); end
        checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", cnt); end
        checks++; if (act !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", act); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", rdy); end
      end
    join
    checks++; if (count_hi(0, 300, 1'b1) !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", count_hi(0, 300, 1'b1)); end
    checks++; if (count_lo_ser(39, 300) !== 0) begin errors++; $display("FAIL rst_no_frames: got %0d low cycles expected 0", count_lo_ser(39, 300)); end
  endtask

  task automatic test_slow_counter();
    int t = 0;
    int len;
    logic v;
    dv2 = 1'b1; byte2 = 8'h55;
    @(negedge clk); dv2 = 1'b0;
    while (ser2 !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    checks++; if (ser2 !== 1'b0) begin errors++; $display("FAIL slow_fall: got %b expected 0", ser2); end
    // 0x55 toggles every bit, so start..b6 are single-bit runs.
    for (int r = 0; r < 8; r++) begin
      v = ser2; len = 0;
      while (ser2 === v && len < 2000) begin @(negedge clk); len++; end
      checks++; if (len !== C2) begin errors++; $display("FAIL slow_run%0d: got %0d expected %0d", r, len, C2); end
    end
    t = 0;
    while (act2 !== 1'b0 && t < 4*C2) begin @(negedge clk); t++; end
    checks++; if (act2 !== 1'b0) begin errors++; $display("FAIL slow_end: active %b expected 0", act2); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b [2];
    logic       p [2];
    int f;
    b[0] = 8'h07; p[0] = 1'b1; b[1] = 8'h03; p[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dv = 1'b1; tb_byte = b[k];
      @(negedge clk); dv = 1'b0;
      record(FL + 20);
      f = find_fall(0, FL + 20);
      checks++; if (f !== 2) begin errors++; $display("FAIL par%0d_fall: at %0d expected 2", k, f); end
      checks++; if (dec(2) !== b[k]) begin errors++; $display("FAIL par%0d_data: got %02h expected %02h", k, dec(2), b[k]); end
      checks++; if (s_ser[2 + C/2 + 9*C] !== p[k]) begin errors++; $display("FAIL par%0d_bit: got %b expected %b", k, s_ser[2 + C/2 + 9*C], p[k]); end
      checks++; if (s_ser[2 + C/2 + 10*C] !== 1'b1) begin errors++; $display("FAIL par%0d_stop: got %b expected 1", k, s_ser[2 + C/2 + 10*C]); end
      checks++; if (count_hi(0, FL + 20, 1'b0) !== 88) begin errors++; $display("FAIL par%0d_len: got %0d expected 88", k, count_hi(0, FL + 20, 1'b0)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_fifo_full();
    repeat (5) @(negedge clk);
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    test_slow_counter();
`ifdef UART_TX_PARITY_EN
    repeat (5) @(negedge clk);
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
